// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver with tear-free frame updates,
// anti-ghost blanking gap, leading-zero blanking and decimal points.
module seg7_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int DIV_WIDTH      = 16,
  parameter int BLANK_CYCLES   = 2,
  parameter bit ACTIVE_LOW_SEG = 1'b0,
  parameter bit ACTIVE_LOW_DIG = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lz_blank,
  input  logic [DIV_WIDTH-1:0]    div_limit,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic                    frame_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int GAP_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

  // {g,f,e,d,c,b,a}, 1 = lit
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

  // A digit is a leading zero when it and every more-significant nibble are 0;
  // digit 0 always shows so a zero value still reads "0".
  function automatic logic [6:0] digit_seg(input logic [4*NUM_DIGITS-1:0] val,
                                           input logic                    lz,
                                           input logic [IDX_W-1:0]        i);
    logic lead_zero;
    lead_zero = lz && (i != '0);
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if (j >= int'(i) && val[4*j +: 4] != 4'h0) lead_zero = 1'b0;
    end
    return lead_zero ? 7'h00 : SEG_LUT[val[4*i +: 4]];
  endfunction

  state_t                  state;
  logic [IDX_W-1:0]        idx;
  logic [DIV_WIDTH-1:0]    presc;
  logic [DIV_WIDTH-1:0]    lim;
  logic [GAP_W-1:0]        gap_cnt;
  logic [4*NUM_DIGITS-1:0] pend_val;
  logic [NUM_DIGITS-1:0]   pend_dp;
  logic [4*NUM_DIGITS-1:0] shadow_val;
  logic [NUM_DIGITS-1:0]   shadow_dp;
  logic [6:0]              seg_r;
  logic                    dp_r;
  logic [NUM_DIGITS-1:0]   dig_r;
  logic                    frame_done_r;

  logic                    wrap;
  logic                    advance;
  logic [IDX_W-1:0]        next_idx;
  logic [4*NUM_DIGITS-1:0] next_val;
  logic [NUM_DIGITS-1:0]   next_dp;

  // NOTE: every variable gets a value on every path of always_comb, so no latch is inferred.
  always_comb begin
    wrap     = (idx == LAST_IDX);
    next_idx = wrap ? '0 : idx + 1'b1;
    advance  = enable && (((state == SHOW) && (presc == lim) && (BLANK_CYCLES == 0)) ||
                          ((state == GAP) && (gap_cnt == LAST_GAP)));
    // A load landing on the frame boundary bypasses pending straight into shadow.
    next_val = shadow_val;
    next_dp  = shadow_dp;
    if (wrap) begin
      next_val = load ? value : pend_val;
      next_dp  = load ? dp_in : pend_dp;
    end
  end

  // NOTE: state is updated with non-blocking assignments only; the async reset clears every register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      idx          <= '0;
      presc        <= '0;
      lim          <= '0;
      gap_cnt      <= '0;
      pend_val     <= '0;
      pend_dp      <= '0;
      shadow_val   <= '0;
      shadow_dp    <= '0;
      seg_r        <= '0;
      dp_r         <= 1'b0;
      dig_r        <= '0;
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= 1'b0;
      if (load) begin
        pend_val <= value;
        pend_dp  <= dp_in;
      end

      if (!enable) begin
        state   <= IDLE;
        idx     <= '0;
        presc   <= '0;
        gap_cnt <= '0;
        seg_r   <= '0;
        dp_r    <= 1'b0;
        dig_r   <= '0;
      end else begin
        case (state)
          IDLE: begin
            state <= SHOW;
            idx   <= '0;
            presc <= '0;
            lim   <= div_limit;
            seg_r <= digit_seg(shadow_val, lz_blank, '0);
            dp_r  <= shadow_dp[0];
            dig_r <= NUM_DIGITS'(1);
          end
          SHOW: begin
            // div_limit is latched on entry so a mid-digit change cannot cut SHOW short.
            if (presc != lim) begin
              presc <= presc + 1'b1;
            end else if (BLANK_CYCLES != 0) begin
              state   <= GAP;
              gap_cnt <= '0;
              seg_r   <= '0;
              dp_r    <= 1'b0;
              dig_r   <= '0;
            end
          end
          GAP: begin
            if (gap_cnt != LAST_GAP) gap_cnt <= gap_cnt + 1'b1;
          end
          default: state <= IDLE;
        endcase

        if (advance) begin
          state <= SHOW;
          idx   <= next_idx;
          presc <= '0;
          lim   <= div_limit;
          seg_r <= digit_seg(next_val, lz_blank, next_idx);
          dp_r  <= next_dp[next_idx];
          dig_r <= NUM_DIGITS'(1) << next_idx;
          if (wrap) begin
            frame_done_r <= 1'b1;
            shadow_val   <= next_val;
            shadow_dp    <= next_dp;
          end
        end
      end
    end
  end

  // Pin polarity is applied after the registers.
  assign seg        = ACTIVE_LOW_SEG ? ~seg_r : seg_r;
  assign dp         = ACTIVE_LOW_SEG ? ~dp_r  : dp_r;
  assign dig_sel    = ACTIVE_LOW_DIG ? ~dig_r : dig_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: directed steps, expected digits queued
// in a scoreboard and compared as each digit appears on the pins.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        lz_blank;
  logic [15:0] div_limit;

  logic [6:0]  seg, seg_n;
  logic        dp, dp_n;
  logic [3:0]  dig_sel, dig_sel_n;
  logic        frame_done, frame_done_n;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .NUM_DIGITS(4), .DIV_WIDTH(16), .BLANK_CYCLES(2),
    .ACTIVE_LOW_SEG(1'b0), .ACTIVE_LOW_DIG(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .value(value),
    .dp_in(dp_in), .lz_blank(lz_blank), .div_limit(div_limit),
    .seg(seg), .dp(dp), .dig_sel(dig_sel), .frame_done(frame_done)
  );

  seg7_scan_driver #(
    .NUM_DIGITS(4), .DIV_WIDTH(16), .BLANK_CYCLES(2),
    .ACTIVE_LOW_SEG(1'b1), .ACTIVE_LOW_DIG(1'b1)
  ) dut_n (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .value(value),
    .dp_in(dp_in), .lz_blank(lz_blank), .div_limit(div_limit),
    .seg(seg_n), .dp(dp_n), .dig_sel(dig_sel_n), .frame_done(frame_done_n)
  );

  localparam logic [6:0] SEG_TAB [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef struct {
    logic [3:0] dig;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
    int         on_len;
    bit         chk_gap;
  } exp_t;

  exp_t sb[$];
  int   passed   = 0;
  int   total    = 0;
  int   entry_no = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) passed++;
    else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp_v);
  endtask

  // Queue the expected digits lo..hi of a frame showing v/d.
  task automatic push_digits(input logic [15:0] v, input logic [3:0] d, input logic lz,
                             input logic fd, input int on_len, input bit chk_first,
                             input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      exp_t       e;
      logic [15:0] upper;
      upper     = v >> (4 * i);
      e.dig     = 4'b0001 << i;
      e.seg     = (lz && i != 0 && upper == 16'h0) ? 7'h00 : SEG_TAB[upper[3:0]];
      e.dp      = d[i];
      e.fd      = (i == 0) ? fd : 1'b0;
      e.on_len  = on_len;
      e.chk_gap = (i == lo) ? chk_first : 1'b1;
      sb.push_back(e);
    end
  endtask

  // Wait for the next lit digit, compare it with the scoreboard head, then time its SHOW.
  task automatic check_next();
    exp_t       e;
    int         waited;
    int         on_cycles;
    logic [3:0] cur;
    if (sb.size() == 0) begin
      total++;
      $error("FAIL scoreboard_empty: observed 0 entries, expected at least 1");
      return;
    end
    e = sb.pop_front();
    entry_no++;
    waited = 0;
    while (dig_sel === 4'b0000 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check($sformatf("entry%0d_out", entry_no),
          32'({dig_sel, seg, dp, frame_done}), 32'({e.dig, e.seg, e.dp, e.fd}));
    check($sformatf("entry%0d_pins_inverted", entry_no),
          32'({dig_sel_n, seg_n, dp_n, frame_done_n}), 32'({~e.dig, ~e.seg, ~e.dp, e.fd}));
    if (e.chk_gap) check($sformatf("entry%0d_gap_len", entry_no), 32'(waited), 32'd2);
    on_cycles = 0;
    cur = dig_sel;
    while (dig_sel === cur && on_cycles < 100) begin
      @(negedge clk);
      on_cycles++;
    end
    check($sformatf("entry%0d_show_len", entry_no), 32'(on_cycles), 32'(e.on_len));
  endtask

  task automatic drain();
    while (sb.size() > 0) check_next();
  endtask

  task automatic wait_dig(input logic [3:0] target, input string tag);
    int n;
    n = 0;
    while (dig_sel !== target && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(dig_sel), 32'(target));
  endtask

  // All pins must stay dark (inverted instance all ones) for the whole window.
  task automatic check_dark(input string tag, input int cycles);
    logic [12:0] seen;
    logic [12:0] seen_n;
    seen   = '0;
    seen_n = '1;
    for (int i = 0; i < cycles; i++) begin
      seen   = seen | {dig_sel, seg, dp, frame_done};
      seen_n = seen_n & {dig_sel_n, seg_n, dp_n, ~frame_done_n};
      @(negedge clk);
    end
    check(tag, 32'(seen), 32'h0);
    check({tag, "_inv"}, 32'(seen_n), 32'h1FFF);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    load  = 1'b1;
    value = v;
    dp_in = d;
    @(negedge clk);
    load  = 1'b0;
  endtask

  initial begin
    int n;
    rst_n     = 1'b0;
    enable    = 1'b0;
    load      = 1'b0;
    value     = 16'h0;
    dp_in     = 4'h0;
    lz_blank  = 1'b0;
    div_limit = 16'd3;

    // Reset state, then stay dark with enable low.
    @(negedge clk);
    check_dark("reset_dark", 2);
    rst_n = 1'b1;
    check_dark("idle_dark", 4);

    // Decode: first frame shows the cleared shadow, then A5C0 arrives at the wrap.
    do_load(16'hA5C0, 4'b0100);
    enable = 1'b1;
    push_digits(16'h0000, 4'b0000, 1'b0, 1'b0, 4, 1'b0, 0, 3);
    push_digits(16'hA5C0, 4'b0100, 1'b0, 1'b1, 4, 1'b1, 0, 3);
    drain();

    // frame_done period: 4 digits x (4 on + 2 gap).
    n = 0;
    while (frame_done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("frame_done_seen", 32'(frame_done), 32'd1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_done !== 1'b1 && n < 100);
    check("frame_period", 32'(n), 32'd24);
    wait_dig(4'b1000, "sync_digit3");
    n = 0;
    while (dig_sel === 4'b1000 && n < 100) begin
      @(negedge clk);
      n++;
    end

    // Tear-free: two loads mid-frame; the rest of the frame keeps A5C0, the last load wins.
    push_digits(16'hA5C0, 4'b0100, 1'b0, 1'b1, 4, 1'b1, 0, 0);
    check_next();
    do_load(16'h1234, 4'b1111);
    push_digits(16'hA5C0, 4'b0100, 1'b0, 1'b0, 4, 1'b0, 1, 3);
    push_digits(16'h5678, 4'b0001, 1'b0, 1'b1, 4, 1'b1, 0, 3);
    load  = 1'b1;
    value = 16'h5678;
    dp_in = 4'b0001;
    @(negedge clk);
    load  = 1'b0;
    drain();

    // Load on the boundary cycle goes straight into the frame that starts on that edge.
    @(negedge clk);
    do_load(16'hEDB9, 4'b0010);
    push_digits(16'hEDB9, 4'b0010, 1'b0, 1'b1, 4, 1'b0, 0, 3);
    drain();

    // Leading-zero blanking.
    lz_blank = 1'b1;
    do_load(16'h0070, 4'b0000);
    push_digits(16'h0070, 4'b0000, 1'b1, 1'b1, 4, 1'b0, 0, 3);
    drain();
    do_load(16'h0000, 4'b1000);
    push_digits(16'h0000, 4'b1000, 1'b1, 1'b1, 4, 1'b0, 0, 3);
    drain();

    // div_limit=0 gives 1-cycle SHOW; the change lands at the next prescaler restart.
    div_limit = 16'd0;
    push_digits(16'h0000, 4'b1000, 1'b1, 1'b1, 1, 1'b1, 0, 3);
    drain();
    div_limit = 16'd3;

    // Enable drop mid-SHOW: dark on the very next cycle.
    wait_dig(4'b0010, "pre_drop_digit1");
    enable = 1'b0;
    @(negedge clk);
    check("drop_show_dark", 32'({dig_sel, seg, dp, frame_done}), 32'h0);
    enable = 1'b1;
    push_digits(16'h0000, 4'b1000, 1'b1, 1'b0, 4, 1'b0, 0, 2);
    drain();

    // Enable drop during GAP of digit 2 with a simultaneous load; shadow is kept.
    enable = 1'b0;
    do_load(16'h0123, 4'b0000);
    check_dark("drop_gap_dark", 5);
    enable = 1'b1;
    push_digits(16'h0000, 4'b1000, 1'b1, 1'b0, 4, 1'b0, 0, 3);
    push_digits(16'h0123, 4'b0000, 1'b1, 1'b1, 4, 1'b1, 0, 3);
    drain();

    // Asynchronous reset mid-scan clears outputs without a clock edge.
    wait_dig(4'b0100, "pre_reset_digit2");
    rst_n = 1'b0;
    #1;
    check("reset_async", 32'({dig_sel, seg, dp, frame_done}), 32'h0);
    check("reset_async_inv", 32'({dig_sel_n, seg_n, dp_n, frame_done_n}), 32'h1FFE);
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_dark("post_reset_dark", 5);

    // Shadow was cleared by reset: digit 0 reads "0", not the old 3.
    lz_blank = 1'b0;
    enable   = 1'b1;
    wait_dig(4'b0001, "restart_digit0");
    check("restart_shadow_cleared", 32'({seg, dp, frame_done}), 32'({7'h3F, 1'b0, 1'b0}));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
